// File: rtl/alu_pkg.sv
// Shared types and encodings for the ID/EX issue stage of the MIPS core.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_LT  = 3'd4,
        ALU_XOR = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_SEXT,
        IMM_ZEXT
    } imm_mode_t;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_RD,
        DEST_RT
    } dest_sel_t;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
    } ex_ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decode: ALU op, immediate mode, destination select,
// control bits, rt usage and illegal flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output imm_mode_t  imm_mode,
    output dest_sel_t  dest_sel,
    output ex_ctrl_t   ctrl,
    output logic       uses_rt,
    output logic       illegal
);

    always_comb begin
        alu_op   = ALU_ADD;
        imm_mode = IMM_NONE;
        dest_sel = DEST_NONE;
        ctrl     = '0;
        uses_rt  = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest_sel      = DEST_RD;
                ctrl.regwrite = 1'b1;
                uses_rt       = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_SLT:          alu_op = ALU_LT;
                    default:         illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                alu_op        = (opcode == OP_SLTI) ? ALU_LT : ALU_ADD;
                imm_mode      = IMM_SEXT;
                dest_sel      = DEST_RT;
                ctrl.regwrite = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_op        = (opcode == OP_ANDI) ? ALU_AND :
                                (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                imm_mode      = IMM_ZEXT;
                dest_sel      = DEST_RT;
                ctrl.regwrite = 1'b1;
            end
            OP_LW: begin
                imm_mode      = IMM_SEXT;
                dest_sel      = DEST_RT;
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
            end
            OP_SW: begin
                imm_mode      = IMM_SEXT;
                uses_rt       = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                alu_op      = ALU_SUB;
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand forwarding/hazard detect and ID/EX register.
// Optional feature macro: ALU_ISSUE_FWD_EN (bypass from EX/MEM and MEM/WB writers).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [WIDTH-1:0]  id_rs_data,
    input  logic [WIDTH-1:0]  id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [WIDTH-1:0]  exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [WIDTH-1:0]  memwb_result,
    output logic              ex_valid,
    output logic [2:0]        ex_alu_control,
    output logic [WIDTH-1:0]  ex_input1,
    output logic [WIDTH-1:0]  ex_input2,
    output logic [WIDTH-1:0]  ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_illegal,
    output logic              raw_hazard
);

    typedef struct packed {
        logic              valid;
        alu_op_t           op;
        logic [WIDTH-1:0]  in1;
        logic [WIDTH-1:0]  in2;
        logic [WIDTH-1:0]  store;
        logic [REG_AW-1:0] dest;
        ex_ctrl_t          ctrl;
        logic              illegal;
    } idex_t;

    alu_op_t   dec_op;
    imm_mode_t dec_imm;
    dest_sel_t dec_dest;
    ex_ctrl_t  dec_ctrl;
    logic      dec_uses_rt;
    logic      dec_illegal;

    alu_decode u_decode (
        .opcode   (id_opcode),
        .funct    (id_funct),
        .alu_op   (dec_op),
        .imm_mode (dec_imm),
        .dest_sel (dec_dest),
        .ctrl     (dec_ctrl),
        .uses_rt  (dec_uses_rt),
        .illegal  (dec_illegal)
    );

    logic ex_hit_rs, ex_hit_rt, wb_hit_rs, wb_hit_rt;
    logic [WIDTH-1:0] rs_val, rt_val;

    assign ex_hit_rs = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == id_rs);
    assign ex_hit_rt = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == id_rt);
    assign wb_hit_rs = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs);
    assign wb_hit_rt = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rt);

`ifdef ALU_ISSUE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = dec_uses_rt;
    assign rs_val     = ex_hit_rs ? exmem_result : wb_hit_rs ? memwb_result : id_rs_data;
    assign rt_val     = ex_hit_rt ? exmem_result : wb_hit_rt ? memwb_result : id_rt_data;
    assign raw_hazard = 1'b0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_result, memwb_result};
    assign rs_val     = id_rs_data;
    assign rt_val     = id_rt_data;
    // rs is read by every legal instruction; rt only by R-type, sw and beq.
    assign raw_hazard = id_valid && !dec_illegal &&
                        (ex_hit_rs || wb_hit_rs || (dec_uses_rt && (ex_hit_rt || wb_hit_rt)));
`endif

    idex_t d, q;

    always_comb begin
        d = '0;
        if (id_valid && dec_illegal) begin
            d.illegal = 1'b1;
        end else if (id_valid) begin
            d.valid = 1'b1;
            d.op    = dec_op;
            d.in1   = rs_val;
            d.store = rt_val;
            case (dec_imm)
                IMM_SEXT: d.in2 = {{(WIDTH-16){id_imm[15]}}, id_imm};
                IMM_ZEXT: d.in2 = {{(WIDTH-16){1'b0}}, id_imm};
                default:  d.in2 = rt_val;
            endcase
            case (dec_dest)
                DEST_RD: d.dest = id_rd;
                DEST_RT: d.dest = id_rt;
                default: d.dest = '0;
            endcase
            d.ctrl = dec_ctrl;
            if (d.dest == '0)
                d.ctrl.regwrite = 1'b0;
        end
    end

    // Reset and flush both load the all-zero bubble; stall holds everything.
    always_ff @(posedge clk) begin
        if (rst || flush)
            q <= '0;
        else if (!stall)
            q <= d;
    end

    assign ex_valid       = q.valid;
    assign ex_alu_control = q.op;
    assign ex_input1      = q.in1;
    assign ex_input2      = q.in2;
    assign ex_store_data  = q.store;
    assign ex_dest        = q.dest;
    assign ex_regwrite    = q.ctrl.regwrite;
    assign ex_memread     = q.ctrl.memread;
    assign ex_memwrite    = q.ctrl.memwrite;
    assign ex_branch      = q.ctrl.branch;
    assign ex_illegal     = q.illegal;

endmodule
